issue_ctrl: RTL and testbench

Issue controller sitting between the IF/ID pipeline register and EX; sequences the decode stage of the SCC pipeline. Tracks in-flight register and flag writes in a per-register scoreboard, and stalls instructions in ID that read a pending result. It flushes wrong-path instructions on a taken branch resolved in EX, and parks the pipeline on HALT until an external resume. It does not decode fields for the datapath; it only gates issue.

---
 rtl/issue_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_issue_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// Issue controller for the SCC decode stage.
// Decides each cycle whether the instruction held in IF/ID may issue to EX.
// It stalls on read-after-write hazards and flushes wrong-path fetches after
// a taken branch. A HALT instruction parks the pipeline until `resume`.
// A small scoreboard of saturating down-counters tracks in-flight writes.
module issue_ctrl #(
    parameter int LOAD_LAT     = 3,  // load-to-use distance in cycles (1..4)
    parameter int ALU_LAT      = 1,  // ALU/flag result distance in cycles (1..4)
    parameter int FLUSH_CYCLES = 2   // cycles IF/ID is invalidated after a taken branch (1..4)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        ex_branch_taken,
    input  logic        resume,
    output logic        id_issue,
    output logic        if_stall,
    output logic        id_bubble,
    output logic        if_flush,
    output logic        halted,
    output logic [7:0]  busy_mask
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Only the facts about the ID instruction that matter for issue gating.
    typedef struct packed {
        logic [7:0] reads;     // one-hot set of source registers read
        logic       wr_reg;    // writes register `dest`
        logic [2:0] dest;
        logic       is_load;   // result arrives after LOAD_LAT instead of ALU_LAT
        logic       wr_flags;  // flag setter
        logic       rd_flags;  // conditional branch consumes flags
        logic       is_halt;
    } dec_t;

    // Counter load values: a result issued now is usable LAT cycles later,
    // so the counter covers the LAT-1 cycles in between.
    localparam logic [1:0] LOAD_INIT  = 2'(LOAD_LAT - 1);
    localparam logic [1:0] ALU_INIT   = 2'(ALU_LAT - 1);
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_t          state, state_nx;
    logic [1:0]      flush_cnt, flush_cnt_nx;
    logic [7:0][1:0] reg_cnt, reg_cnt_nx;
    logic [1:0]      flag_cnt, flag_cnt_nx;

    dec_t dec;
    logic flags_busy;
    logic hazard;

    // Low instruction bits carry immediates and play no part in issue gating.
    logic unused_bits;
    assign unused_bits = ^id_instr[15:0];

    // Classify the ID instruction into reads, writes, flag use and HALT.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        dec      = '0;
        dec.dest = id_instr[24:22];
        case (id_instr[31:30])
            2'b00: begin
                // Data-immediate. mov/movt (sub-op 00000/00001) have no source.
                dec.wr_reg   = 1'b1;
                dec.wr_flags = id_instr[29] & id_instr[28];
                if (id_instr[29:26] != 4'b0000) begin
                    dec.reads[id_instr[21:19]] = 1'b1;
                end
            end
            2'b01: begin
                // Data-register. NOT has a single source.
                dec.wr_reg   = 1'b1;
                dec.wr_flags = id_instr[29] & id_instr[28];
                dec.reads[id_instr[21:19]] = 1'b1;
                if (id_instr[29:25] != 5'b10110) begin
                    dec.reads[id_instr[18:16]] = 1'b1;
                end
            end
            2'b10: begin
                dec.reads[id_instr[21:19]] = 1'b1;
                if (id_instr[25]) begin
                    // Store: the data register sits in the dest field.
                    dec.reads[id_instr[24:22]] = 1'b1;
                end else begin
                    dec.wr_reg  = 1'b1;
                    dec.is_load = 1'b1;
                end
            end
            default: begin
                // System/branch group, decoded in priority order.
                if (id_instr[28:25] == 4'b0000) begin
                    dec.reads = '0;                       // B
                end else if (id_instr[28:25] == 4'b0001) begin
                    dec.rd_flags = 1'b1;                  // Bcond
                end else if (id_instr[28:25] == 4'b0010) begin
                    dec.reads[id_instr[21:19]] = 1'b1;    // BR
                end else if (id_instr[27]) begin
                    dec.reads = '0;                       // NOP
                end else if (id_instr[28]) begin
                    dec.is_halt = 1'b1;                   // HALT
                end
            end
        endcase
    end

    // Scoreboard view: a register or the flags are busy while their counter is nonzero.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            busy_mask[i] = (reg_cnt[i] != 2'd0);
        end
        flags_busy = (flag_cnt != 2'd0);
        // HALT waits until every outstanding write has drained.
        hazard = id_valid &
                 ((|(dec.reads & busy_mask)) |
                  (dec.rd_flags & flags_busy) |
                  (dec.is_halt & ((|busy_mask) | flags_busy)));
    end

    // Next scoreboard contents: age every entry, then account for this issue.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            reg_cnt_nx[i] = (reg_cnt[i] != 2'd0) ? reg_cnt[i] - 2'd1 : 2'd0;
        end
        flag_cnt_nx = (flag_cnt != 2'd0) ? flag_cnt - 2'd1 : 2'd0;
        if (id_issue && dec.wr_reg) begin
            // An older, slower write to the same register may still be pending;
            // keep whichever of the two finishes later.
            if (dec.is_load) begin
                reg_cnt_nx[dec.dest] = (reg_cnt_nx[dec.dest] > LOAD_INIT) ?
                                       reg_cnt_nx[dec.dest] : LOAD_INIT;
            end else begin
                reg_cnt_nx[dec.dest] = (reg_cnt_nx[dec.dest] > ALU_INIT) ?
                                       reg_cnt_nx[dec.dest] : ALU_INIT;
            end
        end
        if (id_issue && dec.wr_flags) begin
            flag_cnt_nx = ALU_INIT;
        end
    end

    // Next control state and flush countdown.
    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        case (state)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    flush_cnt_nx = FLUSH_INIT;
                    // A single-cycle flush is fully covered by this RUN cycle.
                    if (FLUSH_CYCLES > 1) begin
                        state_nx = ST_FLUSH;
                    end
                end else if (id_issue && dec.is_halt) begin
                    state_nx = ST_HALTED;
                end
            end
            ST_FLUSH: begin
                if (ex_branch_taken) begin
                    flush_cnt_nx = FLUSH_INIT;
                end else if (flush_cnt <= 2'd1) begin
                    flush_cnt_nx = 2'd0;
                    state_nx     = ST_RUN;
                end else begin
                    flush_cnt_nx = flush_cnt - 2'd1;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx     = ST_RUN;
                flush_cnt_nx = 2'd0;
            end
        endcase
    end

    // Pipeline control outputs; a taken branch outranks hazard, issue and HALT.
    always_comb begin
        id_issue  = 1'b0;
        if_stall  = 1'b0;
        id_bubble = 1'b1;
        if_flush  = 1'b0;
        // While reset is asserted the outputs hold their idle values even if
        // the fetch side already presents a valid instruction or branch.
        if (rst_n) begin
            case (state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        if_flush = 1'b1;
                    end else if (hazard) begin
                        if_stall = 1'b1;
                    end else if (id_valid) begin
                        id_issue  = 1'b1;
                        id_bubble = 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if_flush = 1'b1;
                end
                ST_HALTED: begin
                    if_stall = 1'b1;
                end
                default: begin
                    id_bubble = 1'b1;
                end
            endcase
        end
    end

    assign halted = (state == ST_HALTED);

    // Control state, flush countdown and scoreboard registers.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    // NOTE: the scoreboard counters are reset along with the control state;
    // a stale nonzero counter after reset would stall unrelated instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            flush_cnt <= 2'd0;
            reg_cnt   <= '0;
            flag_cnt  <= 2'd0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_cnt_nx;
            reg_cnt   <= reg_cnt_nx;
            flag_cnt  <= flag_cnt_nx;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl.
// A reference model tracks, per register, the first cycle a consumer may issue.
// The stimulus side pushes the expected outputs for every cycle into a queue.
// A negedge monitor pops each entry and compares it against the DUT outputs.
module tb_issue_ctrl;

    localparam int LOAD_LAT     = 3;
    localparam int ALU_LAT      = 2;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = 32'h0;
    logic        ex_branch_taken = 1'b0;
    logic        resume = 1'b0;
    logic        id_issue;
    logic        if_stall;
    logic        id_bubble;
    logic        if_flush;
    logic        halted;
    logic [7:0]  busy_mask;

    issue_ctrl #(
        .LOAD_LAT    (LOAD_LAT),
        .ALU_LAT     (ALU_LAT),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .ex_branch_taken(ex_branch_taken),
        .resume         (resume),
        .id_issue       (id_issue),
        .if_stall       (if_stall),
        .id_bubble      (id_bubble),
        .if_flush       (if_flush),
        .halted         (halted),
        .busy_mask      (busy_mask)
    );

    always #5 clk = ~clk;

    // outs = {issue, stall, bubble, flush, halted, busy_mask[7:0]}
    typedef struct packed {
        int          cyc;
        logic [12:0] outs;
    } obs_t;

    typedef struct {
        logic [7:0] reads;
        bit         wr;
        int         dst;
        int         lat;
        bit         flags_w;
        bit         flags_r;
        bit         halt;
    } tb_dec_t;

    obs_t exp_q[$];
    obs_t obs_now;
    int   total = 0;
    int   bad = 0;

    // Reference model: cycle numbers, not counters.
    int ready_reg[8];    // first cycle register r may be consumed
    int ready_flag;      // first cycle flags may be consumed
    int now = 0;         // model cycle index
    bit m_halted = 1'b0;
    int m_flush_left = 0;  // flush cycles still owed after the current one

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // What the instruction set says each instruction reads and writes.
    function automatic tb_dec_t tb_decode(input logic [31:0] w);
        tb_dec_t d;
        int s1, s2;
        s1        = int'(w[21:19]);
        s2        = int'(w[18:16]);
        d.reads   = 8'h00;
        d.wr      = 1'b0;
        d.dst     = int'(w[24:22]);
        d.lat     = ALU_LAT;
        d.flags_w = 1'b0;
        d.flags_r = 1'b0;
        d.halt    = 1'b0;
        case (w[31:30])
            2'b00: begin
                d.wr      = 1'b1;
                d.flags_w = w[29] && w[28];
                if (w[29:25] != 5'b00000 && w[29:25] != 5'b00001) d.reads[s1] = 1'b1;
            end
            2'b01: begin
                d.wr      = 1'b1;
                d.flags_w = w[29] && w[28];
                d.reads[s1] = 1'b1;
                if (w[29:25] != 5'b10110) d.reads[s2] = 1'b1;
            end
            2'b10: begin
                d.reads[s1] = 1'b1;
                if (w[25] == 1'b0) begin
                    d.wr  = 1'b1;
                    d.lat = LOAD_LAT;
                end else begin
                    d.reads[d.dst] = 1'b1;
                end
            end
            default: begin
                if (w[28:25] == 4'd0) d.reads = 8'h00;
                else if (w[28:25] == 4'd1) d.flags_r = 1'b1;
                else if (w[28:25] == 4'd2) d.reads[s1] = 1'b1;
                else if (w[27]) d.reads = 8'h00;
                else if (w[28]) d.halt = 1'b1;
            end
        endcase
        return d;
    endfunction

    // Drive one cycle, predict its outputs, advance the model.
    // taken = the ID slot is freed (issued, flushed, or empty).
    task automatic step(input bit v, input logic [31:0] ins, input bit br, input bit rs,
                        output bit taken);
        tb_dec_t    d;
        obs_t       e;
        logic [7:0] mask;
        bit         fbusy, haz;
        bit         o_issue, o_stall, o_bubble, o_flush, o_halted;
        @(posedge clk);
        #1;
        id_valid        = v;
        id_instr        = ins;
        ex_branch_taken = br;
        resume          = rs;
        d     = tb_decode(ins);
        for (int r = 0; r < 8; r++) mask[r] = (ready_reg[r] > now);
        fbusy    = (ready_flag > now);
        o_issue  = 1'b0;
        o_stall  = 1'b0;
        o_bubble = 1'b1;
        o_flush  = 1'b0;
        o_halted = m_halted;
        taken    = 1'b0;
        if (m_halted) begin
            o_stall = 1'b1;
            if (rs) m_halted = 1'b0;
        end else if (m_flush_left > 0) begin
            o_flush      = 1'b1;
            m_flush_left = br ? FLUSH_CYCLES - 1 : m_flush_left - 1;
            taken        = 1'b1;
        end else if (br) begin
            o_flush      = 1'b1;
            m_flush_left = FLUSH_CYCLES - 1;
            taken        = 1'b1;
        end else begin
            haz = v && (((d.reads & mask) != 8'h00) || (d.flags_r && fbusy) ||
                        (d.halt && (mask != 8'h00 || fbusy)));
            if (haz) begin
                o_stall = 1'b1;
            end else if (v) begin
                o_issue  = 1'b1;
                o_bubble = 1'b0;
                taken    = 1'b1;
                if (d.wr && ready_reg[d.dst] < now + d.lat) ready_reg[d.dst] = now + d.lat;
                if (d.flags_w) ready_flag = now + ALU_LAT;
                if (d.halt) m_halted = 1'b1;
            end else begin
                taken = 1'b1;
            end
        end
        e.cyc  = now;
        e.outs = {o_issue, o_stall, o_bubble, o_flush, o_halted, mask};
        exp_q.push_back(e);
        now++;
    endtask

    task automatic idle(input int n);
        bit tk;
        repeat (n) step(1'b0, 32'h0, 1'b0, 1'b0, tk);
    endtask

    // Hold one instruction in ID until the model says it has left.
    task automatic present(input logic [31:0] ins, input int budget);
        bit tk;
        tk = 1'b0;
        for (int k = 0; k < budget && !tk; k++) step(1'b1, ins, 1'b0, 1'b0, tk);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) ready_reg[r] = 0;
        ready_flag   = 0;
        m_halted     = 1'b0;
        m_flush_left = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy_mask"}, 32'(busy_mask), 32'h00);
        check({tag, " if_flush"},  32'(if_flush),  32'h0);
        check({tag, " halted"},    32'(halted),    32'h0);
        check({tag, " id_bubble"}, 32'(id_bubble), 32'h1);
        check({tag, " id_issue"},  32'(id_issue),  32'h0);
        check({tag, " if_stall"},  32'(if_stall),  32'h0);
    endtask

    // Assert reset away from any edge, with busy inputs applied, and check at once.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #1;
        id_valid        = 1'b1;
        id_instr        = 32'h62D20000;
        ex_branch_taken = 1'b1;
        resume          = 1'b0;
        rst_n           = 1'b0;
        #1;
        check_reset_outputs({tag, " immediate"});
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs({tag, " held"});
        @(negedge clk);
        id_valid        = 1'b0;
        ex_branch_taken = 1'b0;
        rst_n           = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w        = $urandom;
        w[24:22] = 3'($urandom_range(0, 3));
        w[21:19] = 3'($urandom_range(0, 3));
        w[18:16] = 3'($urandom_range(0, 3));
        return w;
    endfunction

    // Monitor: every cycle that has a prediction, compare the DUT outputs.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_now = exp_q.pop_front();
            check($sformatf("cycle %0d {issue,stall,bubble,flush,halted,busy_mask}", obs_now.cyc),
                  32'({id_issue, if_stall, id_bubble, if_flush, halted, busy_mask}),
                  32'(obs_now.outs));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cur;
        bit          have, tk, br, rs;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("power-on reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: load r2<-[r1], then ADD r3=r2+r2 stalls LOAD_LAT-1 cycles.
        step(1'b1, 32'h80880000, 1'b0, 1'b0, tk);
        present(32'h62D20000, 8);
        idle(3);

        // Flag hazard: ADDS then Bcond waits ALU_LAT-1 cycles.
        step(1'b1, 32'h32000000, 1'b0, 1'b0, tk);
        present(32'hC2000000, 6);
        idle(3);

        // Taken branch while ADD is stalled on a load.
        step(1'b1, 32'h80880000, 1'b0, 1'b0, tk);
        step(1'b1, 32'h62D20000, 1'b0, 1'b0, tk);
        step(1'b1, 32'h62D20000, 1'b1, 1'b0, tk);
        repeat (FLUSH_CYCLES) step(1'b1, 32'h62D20000, 1'b0, 1'b0, tk);
        present(32'h62D20000, 6);
        idle(3);

        // HALT drain, park, resume, then a NOP issues at once.
        step(1'b1, 32'h80880000, 1'b0, 1'b0, tk);
        present(32'hD0000000, 8);
        repeat (2) step(1'b1, 32'hC8000000, 1'b0, 1'b0, tk);
        step(1'b1, 32'hC8000000, 1'b0, 1'b1, tk);
        present(32'hC8000000, 4);
        idle(2);

        // WAW: load r2, then mov r2 the next cycle; the load's longer latency wins.
        step(1'b1, 32'h80880000, 1'b0, 1'b0, tk);
        step(1'b1, 32'h00800000, 1'b0, 1'b0, tk);
        idle(4);

        // Branch taken during FLUSH extends it.
        step(1'b1, 32'hC8000000, 1'b1, 1'b0, tk);
        step(1'b1, 32'hC8000000, 1'b1, 1'b0, tk);
        step(1'b1, 32'hC8000000, 1'b0, 1'b0, tk);
        step(1'b1, 32'hC8000000, 1'b0, 1'b0, tk);
        idle(2);

        // Async reset in FLUSH with registers still pending.
        step(1'b1, 32'h80880000, 1'b0, 1'b0, tk);
        step(1'b1, 32'h80400000, 1'b0, 1'b0, tk);
        step(1'b0, 32'h0, 1'b1, 1'b0, tk);
        step(1'b0, 32'h0, 1'b0, 1'b0, tk);
        async_reset("reset in flush");
        idle(2);

        // Randomized traffic with a fetch side that holds ID while not issued.
        have = 1'b0;
        cur  = 32'h0;
        for (int n = 0; n < 800; n++) begin
            if (!have) begin
                cur  = rand_instr();
                have = ($urandom_range(0, 9) != 0);
            end
            br = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 5) == 0);
            step(have, cur, br, rs, tk);
            if (tk) have = 1'b0;
        end

        // Async reset at an arbitrary point in the random run, then settle.
        async_reset("reset after random");
        idle(4);
        @(negedge clk);
        #1;
        check("prediction queue drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
